demo_sequencer: RTL and testbench

Frame-synchronous scheduler that drives the 8-bit `vga_control` command byte consumed by the pixel colour datapath. It plays back a small programmable script, one command per step, with each step held for a programmed number of frames. A user command port can pre-empt the script for a fixed number of frames, after which playback resumes. It sits between the top-level input pins / configuration logic and the pixel colour block.

---
 rtl/demo_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_demo_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/demo_sequencer.sv
// demo_sequencer: frame-synchronous scheduler for the vga_control command byte.
// Plays back a programmable script (one command per step, each held for a number
// of frames) and lets a user command pre-empt the script for OVERRIDE_FRAMES frames.
//
// Ports:
//   clk         pixel clock
//   rst         synchronous active-high reset
//   vsync       VGA vsync level; its rising edge is the frame tick
//   enable      1 = play the script, 0 = idle
//   prog_we     script write strobe
//   prog_addr   script entry index
//   prog_data   script entry: [15:8] command byte, [7:0] hold frames
//   user_cmd    override command byte
//   user_valid  override request
//   user_ready  override can be accepted this cycle
//   vga_control registered command byte to the pixel colour block
//   step_idx    registered current script step
//   overriding  registered, high while in OVERRIDE
module demo_sequencer #(
   parameter int unsigned NUM_STEPS       = 8,
   parameter int unsigned OVERRIDE_FRAMES = 60,
   localparam int unsigned SW             = $clog2(NUM_STEPS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          vsync,
   input  logic          enable,
   input  logic          prog_we,
   input  logic [SW-1:0] prog_addr,
   input  logic [15:0]   prog_data,
   input  logic [7:0]    user_cmd,
   input  logic          user_valid,
   output logic          user_ready,
   output logic [7:0]    vga_control,
   output logic [SW-1:0] step_idx,
   output logic          overriding
);

   typedef enum logic [1:0] {StIdle, StRun, StStall, StOverride} state_e;

   state_e        state_q, state_d;
   state_e        ret_state_q, ret_state_d;
   logic          vsync_q, vsync_d;
   logic [7:0]    vga_q, vga_d;
   logic [SW-1:0] step_q, step_d;
   logic [7:0]    frame_cnt_q, frame_cnt_d;
   logic [7:0]    ovr_cnt_q, ovr_cnt_d;
   logic          tick_seen_q, tick_seen_d;
   logic          overriding_q, overriding_d;
   logic [15:0]   ram_q [NUM_STEPS];
   logic [15:0]   ram_d [NUM_STEPS];

   logic          tick;
   logic          accept;
   logic          do_load;
   logic [SW-1:0] load_k;
   logic          ld_ok;
   logic [SW-1:0] ld_idx;
   logic [7:0]    ld_cmd;
   logic [7:0]    ld_hold;

   assign tick       = vsync & ~vsync_q;
   // Rate limit: a re-accept in OVERRIDE needs a tick since the last accept.
   assign user_ready = (state_q != StOverride) | tick_seen_q;
   assign accept     = user_valid & user_ready;

   // Which entry a load in the current state would target.
   always_comb begin
      load_k = '0;
      unique case (state_q)
         StRun:      load_k = step_q + SW'(1);
         StOverride: load_k = step_q;
         default:    load_k = '0;
      endcase
   end

   // Entry load: fall back to step 0 on an empty entry; fail if step 0 is empty too.
   always_comb begin
      ld_ok   = 1'b0;
      ld_idx  = '0;
      ld_cmd  = ram_q[0][15:8];
      ld_hold = ram_q[0][7:0];
      if (ram_q[load_k][7:0] != 8'd0) begin
         ld_ok   = 1'b1;
         ld_idx  = load_k;
         ld_cmd  = ram_q[load_k][15:8];
         ld_hold = ram_q[load_k][7:0];
      end else if (ram_q[0][7:0] != 8'd0) begin
         ld_ok = 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < int'(NUM_STEPS); i++) begin
         ram_d[i] = ram_q[i];
      end
      if (prog_we) begin
         ram_d[prog_addr] = prog_data;
      end
   end

   always_comb begin
      state_d     = state_q;
      ret_state_d = ret_state_q;
      vsync_d     = vsync;
      vga_d       = vga_q;
      step_d      = step_q;
      frame_cnt_d = frame_cnt_q;
      ovr_cnt_d   = ovr_cnt_q;
      tick_seen_d = tick_seen_q;
      do_load     = 1'b0;

      if (accept) begin
         // A coincident tick is consumed here and does not count toward ovr_cnt.
         vga_d       = user_cmd;
         ovr_cnt_d   = 8'(OVERRIDE_FRAMES);
         tick_seen_d = 1'b0;
         state_d     = StOverride;
         if (state_q != StOverride) begin
            ret_state_d = state_q;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (enable) do_load = 1'b1;
            end
            StRun: begin
               if (!enable) begin
                  state_d = StIdle;
               end else if (tick) begin
                  if (frame_cnt_q > 8'd1) frame_cnt_d = frame_cnt_q - 8'd1;
                  else                    do_load     = 1'b1;
               end
            end
            StStall: begin
               if (!enable)   state_d = StIdle;
               else if (tick) do_load = 1'b1;
            end
            StOverride: begin
               if (tick) begin
                  tick_seen_d = 1'b1;
                  if (ovr_cnt_q > 8'd1) begin
                     ovr_cnt_d = ovr_cnt_q - 8'd1;
                  end else if (ret_state_q == StIdle || !enable) begin
                     // User command stays on vga_control.
                     state_d = StIdle;
                  end else begin
                     do_load = 1'b1;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end

      if (do_load) begin
         if (ld_ok) begin
            vga_d       = ld_cmd;
            step_d      = ld_idx;
            frame_cnt_d = ld_hold;
            state_d     = StRun;
         end else begin
            step_d  = '0;
            state_d = StStall;
         end
      end

      overriding_d = (state_d == StOverride);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         ret_state_q  <= StIdle;
         vsync_q      <= 1'b0;
         vga_q        <= 8'h3F;
         step_q       <= '0;
         frame_cnt_q  <= 8'd0;
         ovr_cnt_q    <= 8'd0;
         tick_seen_q  <= 1'b0;
         overriding_q <= 1'b0;
         for (int i = 0; i < int'(NUM_STEPS); i++) begin
            ram_q[i] <= 16'h3F00;
         end
      end else begin
         state_q      <= state_d;
         ret_state_q  <= ret_state_d;
         vsync_q      <= vsync_d;
         vga_q        <= vga_d;
         step_q       <= step_d;
         frame_cnt_q  <= frame_cnt_d;
         ovr_cnt_q    <= ovr_cnt_d;
         tick_seen_q  <= tick_seen_d;
         overriding_q <= overriding_d;
         for (int i = 0; i < int'(NUM_STEPS); i++) begin
            ram_q[i] <= ram_d[i];
         end
      end
   end

   assign vga_control = vga_q;
   assign step_idx    = step_q;
   assign overriding  = overriding_q;

endmodule

// File: tb/tb_demo_sequencer.sv
// tb_demo_sequencer: directed self-checking bench for demo_sequencer
// (NUM_STEPS = 8, OVERRIDE_FRAMES = 3).
module tb_demo_sequencer;

   localparam int unsigned SW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          vsync = 1'b0;
   logic          enable = 1'b0;
   logic          prog_we = 1'b0;
   logic [SW-1:0] prog_addr = '0;
   logic [15:0]   prog_data = '0;
   logic [7:0]    user_cmd = '0;
   logic          user_valid = 1'b0;
   logic          user_ready;
   logic [7:0]    vga_control;
   logic [SW-1:0] step_idx;
   logic          overriding;

   int pass_cnt = 0;
   int total    = 0;

   demo_sequencer #(
      .NUM_STEPS       (8),
      .OVERRIDE_FRAMES (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .vsync       (vsync),
      .enable      (enable),
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .user_cmd    (user_cmd),
      .user_valid  (user_valid),
      .user_ready  (user_ready),
      .vga_control (vga_control),
      .step_idx    (step_idx),
      .overriding  (overriding)
   );

   always #5 clk = ~clk;

   // Stimulus helpers: inputs change on the falling edge, checks follow a falling edge.
   task automatic cycle();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      enable = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic frame_tick();
      @(negedge clk);
      vsync = 1'b1;
      @(negedge clk);
      vsync = 1'b0;
   endtask

   task automatic write_entry(input logic [SW-1:0] a, input logic [15:0] d);
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic program_basic();
      write_entry(3'd0, 16'h0502);
      write_entry(3'd1, 16'h4201);
      write_entry(3'd2, 16'h8303);
      write_entry(3'd3, 16'h1100);
   endtask

   task automatic set_enable(input logic v);
      @(negedge clk);
      enable = v;
      @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      total++;
      if (vga_control !== 8'h3F) $display("FAIL reset_vga got=%h exp=3f", vga_control);
      else pass_cnt++;
      total++;
      if (step_idx !== 3'd0) $display("FAIL reset_step got=%0d exp=0", step_idx);
      else pass_cnt++;
      total++;
      if (overriding !== 1'b0) $display("FAIL reset_ovr got=%b exp=0", overriding);
      else pass_cnt++;
      total++;
      if (user_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", user_ready);
      else pass_cnt++;
   endtask

   task automatic test_empty_script();
      set_enable(1'b1);
      total++;
      if (vga_control !== 8'h3F || step_idx !== 3'd0)
         $display("FAIL empty_stall got=%h/%0d exp=3f/0", vga_control, step_idx);
      else pass_cnt++;
      frame_tick();
      total++;
      if (vga_control !== 8'h3F) $display("FAIL empty_tick got=%h exp=3f", vga_control);
      else pass_cnt++;
      write_entry(3'd0, 16'h0C01);
      total++;
      if (vga_control !== 8'h3F) $display("FAIL empty_prewrite got=%h exp=3f", vga_control);
      else pass_cnt++;
      frame_tick();
      total++;
      if (vga_control !== 8'h0C || step_idx !== 3'd0)
         $display("FAIL empty_recover got=%h/%0d exp=0c/0", vga_control, step_idx);
      else pass_cnt++;
      set_enable(1'b0);
   endtask

   task automatic test_basic_playback();
      logic [7:0]    exp_vga [6];
      logic [SW-1:0] exp_step [6];
      exp_vga  = '{8'h05, 8'h42, 8'h83, 8'h83, 8'h83, 8'h05};
      exp_step = '{3'd0,  3'd1,  3'd2,  3'd2,  3'd2,  3'd0};
      apply_reset();
      program_basic();
      set_enable(1'b1);
      total++;
      if (vga_control !== 8'h05 || step_idx !== 3'd0)
         $display("FAIL play_start got=%h/%0d exp=05/0", vga_control, step_idx);
      else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
         frame_tick();
         total++;
         if (vga_control !== exp_vga[i] || step_idx !== exp_step[i])
            $display("FAIL play_tick%0d got=%h/%0d exp=%h/%0d", i + 1, vga_control, step_idx,
                     exp_vga[i], exp_step[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_override_mid_step();
      // From step 0 (2 frames): tick->05, tick->42, tick->83 (3), tick-> 83 with 2 left.
      for (int i = 0; i < 4; i++) frame_tick();
      total++;
      if (vga_control !== 8'h83 || step_idx !== 3'd2)
         $display("FAIL ovr_pre got=%h/%0d exp=83/2", vga_control, step_idx);
      else pass_cnt++;
      @(negedge clk);
      user_cmd   = 8'hC0;
      user_valid = 1'b1;
      @(negedge clk);
      user_valid = 1'b0;
      total++;
      if (vga_control !== 8'hC0 || overriding !== 1'b1 || user_ready !== 1'b0)
         $display("FAIL ovr_accept got=%h/%b/%b exp=c0/1/0", vga_control, overriding,
                  user_ready);
      else pass_cnt++;
      frame_tick();
      total++;
      if (user_ready !== 1'b1 || vga_control !== 8'hC0)
         $display("FAIL ovr_ready got=%b/%h exp=1/c0", user_ready, vga_control);
      else pass_cnt++;
      frame_tick();
      total++;
      if (vga_control !== 8'hC0 || overriding !== 1'b1)
         $display("FAIL ovr_hold got=%h/%b exp=c0/1", vga_control, overriding);
      else pass_cnt++;
      frame_tick();
      total++;
      if (vga_control !== 8'h83 || step_idx !== 3'd2 || overriding !== 1'b0)
         $display("FAIL ovr_return got=%h/%0d/%b exp=83/2/0", vga_control, step_idx,
                  overriding);
      else pass_cnt++;
      frame_tick();
      frame_tick();
      total++;
      if (vga_control !== 8'h83) $display("FAIL ovr_fullhold got=%h exp=83", vga_control);
      else pass_cnt++;
      frame_tick();
      total++;
      if (vga_control !== 8'h05 || step_idx !== 3'd0)
         $display("FAIL ovr_next got=%h/%0d exp=05/0", vga_control, step_idx);
      else pass_cnt++;
   endtask

   task automatic test_collision();
      @(negedge clk);
      vsync      = 1'b1;
      user_valid = 1'b1;
      user_cmd   = 8'h81;
      @(negedge clk);
      vsync      = 1'b0;
      user_valid = 1'b0;
      total++;
      if (vga_control !== 8'h81 || overriding !== 1'b1 || step_idx !== 3'd0)
         $display("FAIL coll_accept got=%h/%b/%0d exp=81/1/0", vga_control, overriding,
                  step_idx);
      else pass_cnt++;
      frame_tick();
      frame_tick();
      total++;
      if (vga_control !== 8'h81 || overriding !== 1'b1)
         $display("FAIL coll_count got=%h/%b exp=81/1", vga_control, overriding);
      else pass_cnt++;
      frame_tick();
      total++;
      if (vga_control !== 8'h05 || overriding !== 1'b0)
         $display("FAIL coll_return got=%h/%b exp=05/0", vga_control, overriding);
      else pass_cnt++;
      // Reset in the middle of an override.
      @(negedge clk);
      user_cmd   = 8'hC1;
      user_valid = 1'b1;
      @(negedge clk);
      user_valid = 1'b0;
      total++;
      if (vga_control !== 8'hC1) $display("FAIL coll_reaccept got=%h exp=c1", vga_control);
      else pass_cnt++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (vga_control !== 8'h3F || step_idx !== 3'd0 || overriding !== 1'b0 ||
          user_ready !== 1'b1)
         $display("FAIL coll_rst got=%h/%0d/%b/%b exp=3f/0/0/1", vga_control, step_idx,
                  overriding, user_ready);
      else pass_cnt++;
   endtask

   task automatic test_disable_reenable();
      enable = 1'b0;
      program_basic();
      set_enable(1'b1);
      frame_tick();
      frame_tick();
      total++;
      if (vga_control !== 8'h42 || step_idx !== 3'd1)
         $display("FAIL dis_step1 got=%h/%0d exp=42/1", vga_control, step_idx);
      else pass_cnt++;
      write_entry(3'd1, 16'h7701);
      total++;
      if (vga_control !== 8'h42) $display("FAIL dis_activewrite got=%h exp=42", vga_control);
      else pass_cnt++;
      set_enable(1'b0);
      frame_tick();
      total++;
      if (vga_control !== 8'h42 || step_idx !== 3'd1)
         $display("FAIL dis_idle got=%h/%0d exp=42/1", vga_control, step_idx);
      else pass_cnt++;
      set_enable(1'b1);
      total++;
      if (vga_control !== 8'h05 || step_idx !== 3'd0)
         $display("FAIL dis_restart got=%h/%0d exp=05/0", vga_control, step_idx);
      else pass_cnt++;
   endtask

   initial begin
      cycle();
      test_reset();
      test_empty_script();
      test_basic_playback();
      test_override_mid_step();
      test_collision();
      test_disable_reenable();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
